// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multi-cycle MIPS datapath
// Drives register CEs, mux selects and memory strobes; memory waits are bounded by a timeout.
module multicycle_ctrl #(
  parameter int USE_MEM_READY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_ce,
  output logic        ir_ce,
  output logic        mdr_ce,
  output logic        ab_ce,
  output logic        aluout_ce,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        illegal,
  output logic        mem_err,
  output logic        halted,
  output logic [31:0] instr_cnt,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
    S_MW   = 4'd4,  S_WBM = 4'd5,  S_EXR = 4'd6,  S_WBR = 4'd7,
    S_EXI  = 4'd8,  S_WBI = 4'd9,  S_BR  = 4'd10, S_JMP = 4'd11,
    S_HALT = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ready, mem_state, timeout, retire, op_legal;
  logic        unused_funct;

  // funct is decoded by the ALU control, not here
  assign unused_funct = ^funct;

  assign ready     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign mem_state = (state_q == S_IF) || (state_q == S_MR) || (state_q == S_MW);
  assign timeout   = (TIMEOUT != 0) && mem_state && !ready && (wait_q == WAIT_LAST);
  assign retire    = (state_q == S_WBM) || (state_q == S_WBR) || (state_q == S_WBI) ||
                     (state_q == S_BR)  || (state_q == S_JMP) || ((state_q == S_MW) && ready);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
      OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
      default:              op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= 8'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (timeout) state_d = S_HALT; else if (ready) state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_EXR;
          OP_LW, OP_SW:                     state_d = S_MA;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
          OP_BEQ, OP_BNE:                   state_d = S_BR;
          OP_J:                             state_d = S_JMP;
          default:                          state_d = S_IF;
        endcase
      end
      S_MA:   state_d = (opcode == OP_LW) ? S_MR : S_MW;
      S_MR:   if (timeout) state_d = S_HALT; else if (ready) state_d = S_WBM;
      S_MW:   if (timeout) state_d = S_HALT; else if (ready) state_d = S_IF;
      S_EXR:  state_d = S_WBR;
      S_EXI:  state_d = S_WBI;
      S_WBM, S_WBR, S_WBI, S_BR, S_JMP: state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Wait counter restarts on every state change and saturates rather than wrapping
    if (state_d != state_q)
      wait_d = 8'd0;
    else if (mem_state && !ready && (wait_q != 8'hFF))
      wait_d = wait_q + 8'd1;
    else
      wait_d = wait_q;

    cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
  end

  always_comb begin
    pc_ce = 1'b0; ir_ce = 1'b0; mdr_ce = 1'b0; ab_ce = 1'b0; aluout_ce = 1'b0;
    reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; iord = 1'b0; reg_dst = 1'b0;
    mem_to_reg = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'd0; alu_op = 2'd0;
    pc_src = 2'd0; illegal = 1'b0; mem_err = 1'b0; halted = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd = 1'b1; alu_src_b = 2'd1;
        ir_ce = ready; pc_ce = ready;
      end
      S_ID: begin
        ab_ce = 1'b1; aluout_ce = 1'b1; alu_src_b = 2'd3;
        illegal = !op_legal;
      end
      S_MA:  begin alu_src_a = 1'b1; alu_src_b = 2'd2; aluout_ce = 1'b1; end
      S_MR:  begin mem_rd = 1'b1; iord = 1'b1; mdr_ce = ready; end
      S_WBM: begin reg_we = 1'b1; mem_to_reg = 1'b1; end
      S_MW:  begin mem_wr = 1'b1; iord = 1'b1; end
      S_EXR: begin alu_src_a = 1'b1; alu_op = 2'd2; aluout_ce = 1'b1; end
      S_WBR: begin reg_we = 1'b1; reg_dst = 1'b1; end
      S_EXI: begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd3; aluout_ce = 1'b1; end
      S_WBI: reg_we = 1'b1;
      S_BR: begin
        alu_src_a = 1'b1; alu_op = 2'd1; pc_src = 2'd1;
        pc_ce = (opcode == OP_BEQ) ? zero : !zero;
      end
      S_JMP:  begin pc_src = 2'd2; pc_ce = 1'b1; end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    mem_err = timeout;
    // Enables and strobes drop the instant reset asserts, ahead of the async state reset settling
    if (rst) begin
      pc_ce = 1'b0; ir_ce = 1'b0; mdr_ce = 1'b0; ab_ce = 1'b0; aluout_ce = 1'b0;
      reg_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; illegal = 1'b0; mem_err = 1'b0;
    end
  end

  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_we, mem_rd, mem_wr;
  logic        iord, reg_dst, mem_to_reg, alu_src_a, illegal, mem_err, halted;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [31:0] instr_cnt;
  logic [3:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.USE_MEM_READY(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_ce(pc_ce), .ir_ce(ir_ce), .mdr_ce(mdr_ce), .ab_ce(ab_ce), .aluout_ce(aluout_ce),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal(illegal), .mem_err(mem_err), .halted(halted),
    .instr_cnt(instr_cnt), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to the next cycle's sampling point with the given mem_ready
  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    cyc_n++;
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_pc_ce", pc_ce, 0);
    check("rst_ir_ce", ir_ce, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_alu_src_b", alu_src_b, 1);
    check("rst_cnt", instr_cnt, 0);

    // add: IF ID EXR WBR
    @(negedge clk); rst = 1'b0; #1; cyc_n = 0;
    check("add_if_state", state, 0);
    check("add_if_mem_rd", mem_rd, 1);
    check("add_if_ir_ce", ir_ce, 1);
    check("add_if_pc_ce", pc_ce, 1);
    cyc(1);
    check("add_id_state", state, 1);
    check("add_id_ab_ce", ab_ce, 1);
    check("add_id_alu_src_b", alu_src_b, 3);
    cyc(1);
    check("add_exr_state", state, 6);
    check("add_exr_alu_op", alu_op, 2);
    check("add_exr_aluout_ce", aluout_ce, 1);
    cyc(1);
    check("add_wbr_state", state, 7);
    check("add_wbr_reg_we", reg_we, 1);
    check("add_wbr_reg_dst", reg_dst, 1);
    check("add_wbr_cnt", instr_cnt, 0);
    cyc(1);
    check("add_done_state", state, 0);
    check("add_done_cnt", instr_cnt, 1);
    check("add_cycles", cyc_n, 4);

    // lw with three not-ready cycles in MR
    opcode = 6'h23; cyc_n = 0;
    cyc(1);
    check("lw_id_state", state, 1);
    cyc(1);
    check("lw_ma_state", state, 2);
    check("lw_ma_alu_src_b", alu_src_b, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      check("lw_mr_wait_state", state, 3);
      check("lw_mr_wait_mdr_ce", mdr_ce, 0);
      check("lw_mr_wait_iord", iord, 1);
    end
    cyc(1);
    check("lw_mr_ready_mdr_ce", mdr_ce, 1);
    cyc(1);
    check("lw_wbm_state", state, 5);
    check("lw_wbm_mem_to_reg", mem_to_reg, 1);
    check("lw_wbm_reg_we", reg_we, 1);
    cyc(1);
    check("lw_done_state", state, 0);
    check("lw_done_cnt", instr_cnt, 2);
    check("lw_cycles", cyc_n, 8);

    // beq taken then not taken
    opcode = 6'h04; zero = 1'b1; cyc_n = 0;
    cyc(1); cyc(1);
    check("beq_t_state", state, 10);
    check("beq_t_pc_ce", pc_ce, 1);
    check("beq_t_pc_src", pc_src, 1);
    check("beq_t_alu_op", alu_op, 1);
    cyc(1);
    check("beq_t_cnt", instr_cnt, 3);
    check("beq_t_cycles", cyc_n, 3);
    zero = 1'b0;
    cyc(1); cyc(1);
    check("beq_nt_state", state, 10);
    check("beq_nt_pc_ce", pc_ce, 0);
    cyc(1);
    check("beq_nt_cnt", instr_cnt, 4);

    // illegal opcode
    opcode = 6'h3F;
    cyc(1);
    check("ill_id_pulse", illegal, 1);
    cyc(1);
    check("ill_next_state", state, 0);
    check("ill_gone", illegal, 0);
    check("ill_cnt", instr_cnt, 4);

    // jump
    opcode = 6'h02;
    cyc(1); cyc(1);
    check("j_state", state, 11);
    check("j_pc_src", pc_src, 2);
    check("j_pc_ce", pc_ce, 1);
    cyc(1);
    check("j_cnt", instr_cnt, 5);

    // sw, reset asserted mid-MW
    opcode = 6'h2B;
    cyc(1); cyc(1); cyc(0);
    check("sw_mw_state", state, 4);
    check("sw_mw_mem_wr", mem_wr, 1);
    check("sw_mw_mem_rd", mem_rd, 0);
    #1 rst = 1'b1; #1;
    check("sw_rst_mem_wr", mem_wr, 0);
    check("sw_rst_state", state, 0);
    check("sw_rst_cnt", instr_cnt, 0);

    // timeout: ready held low in IF
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    check("to_c1_mem_err", mem_err, 0);
    cyc(0); cyc(0);
    check("to_c3_mem_err", mem_err, 0);
    check("to_c3_mem_rd", mem_rd, 1);
    cyc(0);
    check("to_c4_mem_err", mem_err, 1);
    check("to_c4_ir_ce", ir_ce, 0);
    cyc(0);
    check("to_halt_state", state, 12);
    check("to_halted", halted, 1);
    check("to_halt_mem_rd", mem_rd, 0);
    check("to_halt_mem_err", mem_err, 0);
    cyc(1);
    check("to_halt_sticky", state, 12);

    // ready arrives on the 4th wait cycle
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    check("rdy_c1_state", state, 0);
    cyc(0); cyc(0); cyc(1);
    check("rdy_c4_mem_err", mem_err, 0);
    check("rdy_c4_ir_ce", ir_ce, 1);
    cyc(1);
    check("rdy_next_state", state, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
